fifo_flow_ctrl: RTL and testbench
=================================

# fifo_flow_ctrl

Parametrised synchronous FIFO with valid/ready on both sides, for buffering between ALU-side producers and consumers where the downstream side needs occupancy information for flow control. It adds four things over the basic FIFO:
- exact occupancy for any `DEPTH`, including non-power-of-two;
- runtime-programmable almost-full and almost-empty flags;
- a synchronous flush;
- a clearable peak-occupancy watermark.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: payload width in bits; must be ≥ 1.
- `DEPTH`, default 8: number of entries; must be ≥ 2; need not be a power of two.

Derived widths (from package):
- `PTR_W` = `$clog2(DEPTH)`.
- `CNT_W` = `$clog2(DEPTH+1)`.

Ports (clock and reset first):
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `arst_n` in 1: reset, synchronous and active-low.
- `data_in` in `DATA_WIDTH`: write payload.
- `data_in_valid` in 1: producer has data.
- `data_in_ready` out 1: FIFO can accept data.
- `data_out` out `DATA_WIDTH`: head-of-queue payload.
- `data_out_valid` out 1: head entry is valid.
- `data_out_ready` in 1: consumer takes the head entry.
- `flush` in 1: discard all contents on the next edge.
- `af_thresh` in `CNT_W`: almost-full threshold.
- `ae_thresh` in `CNT_W`: almost-empty threshold.
- `level` out `CNT_W`: current occupancy, 0..`DEPTH`.
- `almost_full` out 1: `level >= af_thresh`.
- `almost_empty` out 1: `level <= ae_thresh`.
- `peak_level` out `CNT_W`: maximum `level` since the last reset or clear.
- `peak_clr` in 1: reset the watermark.

## Operation

Handshakes:
- Write handshake: `data_in_valid & data_in_ready`.
- Read handshake: `data_out_valid & data_out_ready`.
- `data_in_ready = (level < DEPTH)` and low while `arst_n` is low.
- `data_out_valid = (level != 0)`.
- Neither output depends combinationally on the opposite side's valid/ready.

Storage and pointers:
- Write stores `data_in` at `wr_ptr`. Read advances `rd_ptr`.
- Pointers wrap from `DEPTH-1` to 0 explicitly, so non-power-of-two depths work.
- `data_out` = `mem[rd_ptr]`, combinational. Its value is don't-care while `data_out_valid` is low.

Level update per edge:
- Write only: +1.
- Read only: −1.
- Both, or neither: unchanged.
- `level` never exceeds `DEPTH` or goes below 0. The handshake gating guarantees this; no saturation logic.

Full with simultaneous read:
- `data_in_ready` is 0 when full, so no write is accepted.
- The read proceeds and `level` becomes `DEPTH-1`.

Empty:
- No read is possible.
- A write makes `data_out_valid` rise on the following cycle. There is no same-cycle bypass.

Flush:
- On the edge where `flush` is 1: `wr_ptr`, `rd_ptr` and `level` go to 0.
- Any handshakes in that cycle are discarded: the write is dropped and the read is not counted.
- Memory contents are not cleared.
- `peak_level` is unaffected by flush.

Priority: reset > flush > handshakes.

Flags:
- `almost_full` and `almost_empty` are combinational from the registered `level` and the live threshold inputs.
- A threshold change takes effect in the same cycle.
- `af_thresh = 0` makes `almost_full` constantly 1.
- `ae_thresh >= DEPTH` makes `almost_empty` constantly 1.

Watermark:
- Each edge: `peak_level <= peak_clr ? level_next : max(peak_level, level_next)`.
- `level_next` is the post-edge occupancy.

## Timing

Reset (`arst_n` low at an edge), values after that edge:
- `level` = 0, `wr_ptr` = 0, `rd_ptr` = 0, `peak_level` = 0.
- `data_out_valid` = 0, `almost_empty` = 1, `almost_full` = (`af_thresh == 0`).
- `data_in_ready` = 0 while `arst_n` is low, 1 from the first cycle after release.

Reset mid-operation: all contents are lost, exactly as for a flush, and the watermark is also cleared.

Latency and throughput:
- Write-to-read latency is 1 cycle: data written at edge N is visible and valid after edge N.
- Sustained throughput is one write plus one read per cycle at any level, except that no write is accepted at `level == DEPTH`.

## Structure

Package `fifo_pkg` holds:
- functions `ptr_w(depth)` and `cnt_w(depth)`;
- function `wrap_inc(ptr, depth)`.

Sub-module `fifo_wrap_ptr`:
- parameter `DEPTH`;
- inputs `clk_i`, `arst_n`, `inc`, `clr`; output `ptr`;
- a wrap-around pointer register with a synchronous clear;
- instantiated twice, once each for the write and read pointers.

Top level holds the storage array, level counter, flags and watermark.

## Test plan

Defaults `DATA_WIDTH=8`, `DEPTH=5`, `af_thresh=4`, `ae_thresh=1` unless stated.

1. Fill, drain and wrap: write 0x10..0x14 with `data_out_ready=0`.
   - `level` reaches 5 and `data_in_ready` drops.
   - Drain and write 0x20..0x24 twice; reads return exact order. Pointers wrap 4→0 twice.
2. Full with simultaneous read and write: at `level=5`, assert both valids.
   - Only the read completes; `level=4`.
   - Next cycle, read plus write together: `level` stays 4 and order is preserved.
3. Flags: step `level` 0→5→0.
   - `almost_empty` is 1 at levels 0–1.
   - `almost_full` is 1 at levels 4–5.
   - Change `af_thresh` to 2 at `level=3`: `almost_full` rises the same cycle.
4. Flush during traffic: at `level=3`, with a write and a read in the same cycle as `flush`.
   - Next cycle: `level=0`, `data_out_valid=0`, `peak_level=3`.
   - The next write of 0xAA reads back as 0xAA.
5. Watermark:
   - Fill to 4 and drain to 1: `peak_level=4`.
   - Pulse `peak_clr` with no traffic: `peak_level=1`.
   - Write 2: `peak_level=3`.
6. Reset mid-operation: drop `arst_n` for 1 cycle at `level=4`.
   - All outputs take their reset values.
   - `data_in_ready=0` during reset and 1 the cycle after release.
   - No stale data is presented.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared sizing and pointer helpers for the flow-controlled FIFO.
//   ptr_w(depth)          : bits needed to address 0..depth-1
//   cnt_w(depth)          : bits needed to hold an occupancy of 0..depth
//   wrap_inc(ptr, depth)  : ptr+1, wrapping from depth-1 back to 0
// ---------------------------------------------------------------------------
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The wrap is an explicit compare rather than a natural binary rollover,
  // so depths that are not a power of two stay in range.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// ---------------------------------------------------------------------------
// fifo_wrap_ptr
// Wrap-around pointer register, 0..DEPTH-1, with a synchronous clear.
// Ports:
//   clk_i  in  : clock
//   arst_n in  : synchronous active-low reset
//   inc    in  : advance the pointer by one (wrapping)
//   clr    in  : return the pointer to 0 (wins over inc)
//   ptr    out : current pointer value
// ---------------------------------------------------------------------------
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = PTR_W'(wrap_inc(32'(ptr_q), DEPTH));
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_flow_ctrl
// Synchronous valid/ready FIFO with exact occupancy, programmable almost
// flags, synchronous flush and a clearable peak-occupancy watermark.
// Ports:
//   clk_i          in  : clock, all state changes on the rising edge
//   arst_n         in  : synchronous active-low reset
//   data_in        in  : write payload
//   data_in_valid  in  : producer has data
//   data_in_ready  out : FIFO can accept (level < DEPTH, low in reset)
//   data_out       out : head-of-queue payload (don't-care when not valid)
//   data_out_valid out : head entry is valid (level != 0)
//   data_out_ready in  : consumer takes the head entry
//   flush          in  : discard all contents at the next edge
//   af_thresh      in  : almost-full threshold  (almost_full  = level >= af)
//   ae_thresh      in  : almost-empty threshold (almost_empty = level <= ae)
//   level          out : current occupancy 0..DEPTH
//   almost_full    out : see af_thresh
//   almost_empty   out : see ae_thresh
//   peak_level     out : highest level since reset or last peak_clr
//   peak_clr       in  : restart the watermark from the post-edge level
// ---------------------------------------------------------------------------
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int PTR_W      = ptr_w(DEPTH),
  localparam int CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [CNT_W-1:0]      level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      peak_level,
  input  logic                  peak_clr
);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [CNT_W-1:0]      peak_q, peak_d;
  logic                  wr_hs, rd_hs;

  // Ready/valid come only from the registered level (and reset), never from
  // the other side's handshake, so there is no combinational path through.
  assign data_in_ready  = arst_n && (level_q < FULL_LVL);
  assign data_out_valid = (level_q != '0);

  assign wr_hs = data_in_valid  && data_in_ready;
  assign rd_hs = data_out_valid && data_out_ready;

  // Pointers: flush clears, which the sub-module gives priority over inc.
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .arst_n(arst_n),
    .inc   (wr_hs),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .arst_n(arst_n),
    .inc   (rd_hs),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  // Handshake gating alone keeps level inside 0..DEPTH.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (wr_hs && !rd_hs) begin
      level_d = level_q + ONE;
    end else if (rd_hs && !wr_hs) begin
      level_d = level_q - ONE;
    end
  end

  // The watermark tracks the post-edge occupancy, so a clear restarts it at
  // whatever the level becomes on that same edge.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      level_q <= '0;
      peak_q  <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through data_out while data_out_valid is high, which requires a write.
  always_ff @(posedge clk_i) begin
    if (wr_hs && !flush) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  assign data_out     = mem_q[rd_ptr];
  assign level        = level_q;
  assign peak_level   = peak_q;
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_flow_ctrl
// Directed bench for fifo_flow_ctrl (DATA_WIDTH=8, DEPTH=5). A queue holds
// the payloads the FIFO should contain; it is pushed when a write handshake
// is expected and popped and compared when a read handshake is expected.
// Occupancy, watermark and flags come from a small counter model.
// ---------------------------------------------------------------------------
module tb_fifo_flow_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = 3;

  logic          clk_i = 1'b0;
  logic          arst_n;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          flush;
  logic [CW-1:0] af_thresh;
  logic [CW-1:0] ae_thresh;
  logic [CW-1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] peak_level;
  logic          peak_clr;

  fifo_flow_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .arst_n        (arst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .flush         (flush),
    .af_thresh     (af_thresh),
    .ae_thresh     (ae_thresh),
    .level         (level),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .peak_level    (peak_level),
    .peak_clr      (peak_clr)
  );

  always #5 clk_i = ~clk_i;

  int        n_total  = 0;
  int        n_passed = 0;
  logic [DW-1:0] sb [$];
  int        m_lvl    = 0;
  int        m_peak   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every observable output against the model at the current time.
  task automatic check_state(input string tag);
    check({tag, ":level"},     32'(level),          32'(m_lvl));
    check({tag, ":peak"},      32'(peak_level),     32'(m_peak));
    check({tag, ":in_ready"},  32'(data_in_ready),  32'(arst_n && m_lvl < DEPTH));
    check({tag, ":out_valid"}, 32'(data_out_valid), 32'(m_lvl != 0));
    check({tag, ":af"},        32'(almost_full),    32'(m_lvl >= int'(af_thresh)));
    check({tag, ":ae"},        32'(almost_empty),   32'(m_lvl <= int'(ae_thresh)));
  endtask

  // One clock cycle: drive inputs just after the previous edge, check the
  // pre-edge state (and the head payload if a read is due), then advance the
  // model across the edge.
  task automatic step(input string tag, input logic wv, input logic [DW-1:0] wd,
                      input logic rr, input logic fl, input logic pc);
    logic          wr, rd;
    logic [DW-1:0] exp_d;
    data_in_valid  = wv;
    data_in        = wd;
    data_out_ready = rr;
    flush          = fl;
    peak_clr       = pc;
    #1;
    check_state(tag);
    wr = wv && (m_lvl < DEPTH);
    rd = rr && (m_lvl > 0);
    if (rd) begin
      exp_d = sb.pop_front();
      check({tag, ":data"}, 32'(data_out), 32'(exp_d));
    end
    @(posedge clk_i);
    #1;
    if (fl) begin
      sb.delete();
      m_lvl = 0;
    end else begin
      if (wr) sb.push_back(wd);
      m_lvl = m_lvl + (wr ? 1 : 0) - (rd ? 1 : 0);
    end
    m_peak = pc ? m_lvl : ((m_lvl > m_peak) ? m_lvl : m_peak);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    data_in_valid = 1'b0; data_out_ready = 1'b0; flush = 1'b0; peak_clr = 1'b0;
    @(posedge clk_i);
    #1;
    sb.delete();
    m_lvl  = 0;
    m_peak = 0;
    check({tag, ":rst_level"},     32'(level),          32'd0);
    check({tag, ":rst_peak"},      32'(peak_level),     32'd0);
    check({tag, ":rst_in_ready"},  32'(data_in_ready),  32'd0);
    check({tag, ":rst_out_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, ":rst_ae"},        32'(almost_empty),   32'd1);
    check({tag, ":rst_af"},        32'(almost_full),    32'(af_thresh == '0));
    arst_n = 1'b1;
    #1;
    check({tag, ":rel_in_ready"},  32'(data_in_ready),  32'd1);
  endtask

  initial begin
    arst_n = 1'b0;
    data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    flush = 1'b0; peak_clr = 1'b0;
    af_thresh = 3'd4;
    ae_thresh = 3'd1;
    @(posedge clk_i);
    #1;
    do_reset("init");

    // 1. Fill to full, then drain and refill twice so both pointers wrap.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    check("full_level", 32'(level), 32'd5);
    check("full_ready", 32'(data_in_ready), 32'd0);

    // 2. At full both valids: only the read happens; then a true read+write.
    step("full_rw", 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    check("full_rw_level", 32'(level), 32'd4);
    step("rw4", 1'b1, 8'h9A, 1'b1, 1'b0, 1'b0);
    check("rw4_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) step("wrap_w", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("wrap_r", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end

    // 3. Flags across 0..5..0, plus a live threshold change at level 3.
    for (int i = 0; i < 3; i++) step("flag_up", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    check("af_at3_thr4", 32'(almost_full), 32'd0);
    af_thresh = 3'd2;
    #1;
    check("af_at3_thr2", 32'(almost_full), 32'd1);
    af_thresh = 3'd4;
    for (int i = 3; i < DEPTH; i++) step("flag_up", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("flag_dn", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("flag_end");

    // 4. Flush at level 3 with a write and read in the same cycle.
    step("pclr0", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(data_out_valid), 32'd0);
    check("flush_peak",  32'(peak_level), 32'd3);
    step("post_flush_w", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step("post_flush_r", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 5. Watermark: peak 4, clear at level 1, then two writes.
    step("pclr1", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("wm_up", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("wm_dn", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("wm_peak4", 32'(peak_level), 32'd4);
    step("wm_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("wm_peak1", 32'(peak_level), 32'd1);
    for (int i = 0; i < 2; i++) step("wm_w2", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    check("wm_peak3", 32'(peak_level), 32'd3);

    // 6. Reset at level 4: everything returns to reset values, no stale head.
    step("pre_rst", 1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd4);
    do_reset("midrst");
    step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", 32'(data_out_valid), 32'd0);
    step("post_rst_w", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    step("post_rst_r", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("final");

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
